// File: rtl/inst_queue_pkg.sv
// Shared types and constants for the fetch-to-decode instruction queue.
package inst_queue_pkg;

    typedef logic [31:0] InstAddr_t;
    typedef logic [31:0] Inst_t;

    typedef struct packed {
        InstAddr_t pc;
        Inst_t     inst;
    } InstQueueEntry_t;

    localparam int        INST_QUEUE_DEPTH = 8;
    localparam int        ENTRY_W          = $bits(InstQueueEntry_t);
    localparam logic [31:0] ZERO_WORD      = 32'h0000_0000;

    function automatic logic [1:0] min_count(input logic [1:0] a, input logic [1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/inst_queue_chk.sv
// Simulation checker: decode must not consume more instructions than are presented.
module inst_queue_chk (
    input logic       clk,
    input logic       rst_n,
    input logic       flush,
    input logic [1:0] pop_count,
    input logic       pop_valid1,
    input logic       pop_valid2
);

    logic [1:0] avail_s;

    assign avail_s = {1'b0, pop_valid1} + {1'b0, pop_valid2};

    a_pop_legal: assert property (@(posedge clk) disable iff (!rst_n || flush)
        pop_count <= avail_s);

endmodule

// File: rtl/inst_queue_mem.sv
// Instruction queue storage: DEPTH entries, two write ports, two read ports, data not reset.
module inst_queue_mem
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = INST_QUEUE_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we0,
    input  logic [AW-1:0]      waddr0,
    input  logic [ENTRY_W-1:0] wdata0,
    input  logic               we1,
    input  logic [AW-1:0]      waddr1,
    input  logic [ENTRY_W-1:0] wdata1,
    input  logic [AW-1:0]      raddr0,
    input  logic [AW-1:0]      raddr1,
    output logic [ENTRY_W-1:0] rdata0,
    output logic [ENTRY_W-1:0] rdata1
);

    logic [ENTRY_W-1:0] mem_r [DEPTH];

    // Write ports never target the same slot: they are always consecutive addresses.
    always_ff @(posedge clk) begin
        if (we0) begin
            mem_r[waddr0] <= wdata0;
        end
        if (we1) begin
            mem_r[waddr1] <= wdata1;
        end
    end

    assign rdata0 = mem_r[raddr0];
    assign rdata1 = mem_r[raddr1];

endmodule

// File: rtl/inst_queue.sv
// Fetch-to-decode instruction queue with pair push and 0/1/2 pop.
// Optional same-cycle bypass into decode when empty: define INST_QUEUE_BYPASS_EN.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = INST_QUEUE_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push_valid,
    input  logic [31:0]              push_pc,
    input  logic [31:0]              push_inst1,
    input  logic [31:0]              push_inst2,
    input  logic                     push_inst2_valid,
    output logic                     push_ready,
    output logic                     pop_valid1,
    output logic                     pop_valid2,
    output logic [31:0]              pop_pc1,
    output logic [31:0]              pop_pc2,
    output logic [31:0]              pop_inst1,
    output logic [31:0]              pop_inst2,
    input  logic [1:0]               pop_count,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]      rptr_r, wptr_r, rptr1_s, wptr1_s, count_s, free_s;
    logic               empty_s, push_acc_s, bypass_s;
    logic [1:0]         push_n_s, head_avail_s, avail_s, pop_n_s;
    logic [31:0]        push_pc2_s;
    logic [ENTRY_W-1:0] rd0_s, rd1_s;

    assign count_s    = wptr_r - rptr_r;
    assign free_s     = PW'(DEPTH) - count_s;
    assign empty_s    = (rptr_r == wptr_r);
    assign rptr1_s    = rptr_r + PW'(1);
    assign wptr1_s    = wptr_r + PW'(1);
    assign push_pc2_s = push_pc + 32'd4;

    assign push_ready = (free_s >= PW'(2));
    assign count      = count_s;
    assign push_acc_s = push_valid && push_ready && !flush;
    assign push_n_s   = push_acc_s ? (push_inst2_valid ? 2'd2 : 2'd1) : 2'd0;

`ifdef INST_QUEUE_BYPASS_EN
    assign bypass_s = empty_s && push_acc_s;
`else
    assign bypass_s = 1'b0;
`endif

    // Number of instructions presented at the head from stored state.
    always_comb begin
        if (count_s >= PW'(2)) begin
            head_avail_s = 2'd2;
        end else begin
            head_avail_s = count_s[1:0];
        end
    end

    // Over-consumption by decode is clamped to what was actually presented.
    assign avail_s = bypass_s ? push_n_s : head_avail_s;
    assign pop_n_s = flush ? 2'd0 : min_count(pop_count, avail_s);

    // Pop slot drive: bypassed push data when empty, else the two head entries.
    always_comb begin
        pop_valid1 = 1'b0;
        pop_valid2 = 1'b0;
        pop_pc1    = ZERO_WORD;
        pop_inst1  = ZERO_WORD;
        pop_pc2    = ZERO_WORD;
        pop_inst2  = ZERO_WORD;
        if (bypass_s) begin
            pop_valid1 = 1'b1;
            pop_pc1    = push_pc;
            pop_inst1  = push_inst1;
            if (push_inst2_valid) begin
                pop_valid2 = 1'b1;
                pop_pc2    = push_pc2_s;
                pop_inst2  = push_inst2;
            end else begin
                pop_valid2 = 1'b0;
            end
        end else begin
            if (!empty_s) begin
                pop_valid1 = 1'b1;
                pop_pc1    = rd0_s[63:32];
                pop_inst1  = rd0_s[31:0];
            end else begin
                pop_valid1 = 1'b0;
            end
            if (head_avail_s == 2'd2) begin
                pop_valid2 = 1'b1;
                pop_pc2    = rd1_s[63:32];
                pop_inst2  = rd1_s[31:0];
            end else begin
                pop_valid2 = 1'b0;
            end
        end
    end

    // Pointer update; flush discards everything including this cycle's push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_r <= {PW{1'b0}};
            wptr_r <= {PW{1'b0}};
        end else if (flush) begin
            rptr_r <= {PW{1'b0}};
            wptr_r <= {PW{1'b0}};
        end else begin
            rptr_r <= rptr_r + PW'(pop_n_s);
            wptr_r <= wptr_r + PW'(push_n_s);
        end
    end

    inst_queue_mem #(.DEPTH(DEPTH)) u_mem (
        .clk    (clk),
        .we0    (push_acc_s),
        .waddr0 (wptr_r[AW-1:0]),
        .wdata0 ({push_pc, push_inst1}),
        .we1    (push_acc_s && push_inst2_valid),
        .waddr1 (wptr1_s[AW-1:0]),
        .wdata1 ({push_pc2_s, push_inst2}),
        .raddr0 (rptr_r[AW-1:0]),
        .raddr1 (rptr1_s[AW-1:0]),
        .rdata0 (rd0_s),
        .rdata1 (rd1_s)
    );

    inst_queue_chk u_chk (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .pop_count  (pop_count),
        .pop_valid1 (pop_valid1),
        .pop_valid2 (pop_valid2)
    );

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: directed test-plan sequence followed by random traffic.
module tb_inst_queue;
    import inst_queue_pkg::*;

    localparam int DEPTH = 8;

    logic        clk, rst_n, flush, push_valid, push_inst2_valid, push_ready;
    logic [31:0] push_pc, push_inst1, push_inst2;
    logic        pop_valid1, pop_valid2;
    logic [31:0] pop_pc1, pop_pc2, pop_inst1, pop_inst2;
    logic [1:0]  pop_count;
    logic [3:0]  count;

    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
    typedef struct {
        int          cnt;
        bit          rdy, v1, v2;
        logic [31:0] pc1, pc2, i1, i2;
    } exp_t;

    ent_t mq[$];
    exp_t sb[$];
    int   tests_run = 0;
    int   failed    = 0;

    inst_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .push_valid(push_valid), .push_pc(push_pc),
        .push_inst1(push_inst1), .push_inst2(push_inst2),
        .push_inst2_valid(push_inst2_valid), .push_ready(push_ready),
        .pop_valid1(pop_valid1), .pop_valid2(pop_valid2),
        .pop_pc1(pop_pc1), .pop_pc2(pop_pc2),
        .pop_inst1(pop_inst1), .pop_inst2(pop_inst2),
        .pop_count(pop_count), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One cycle: drive inputs at negedge, record expected outputs, advance the model.
    task automatic step(input bit rn, input bit fl, input bit pv, input logic [31:0] ppc,
                        input logic [31:0] i1, input logic [31:0] i2, input bit i2v,
                        input int preq);
        exp_t e;
        ent_t pushed[$];
        ent_t view[$];
        bit   rdy, acc, byp;
        int   vis, npop;
        @(negedge clk);
        if (!rn) begin
            mq.delete();
            fl = 1'b0; pv = 1'b0; i2v = 1'b0; preq = 0;
        end
        rdy = ((DEPTH - mq.size()) >= 2);
        acc = rn && pv && rdy && !fl;
        if (acc) begin
            pushed.push_back('{ppc, i1});
            if (i2v) pushed.push_back('{ppc + 32'd4, i2});
        end
        byp = 1'b0;
`ifdef INST_QUEUE_BYPASS_EN
        byp = acc && (mq.size() == 0);
`endif
        if (byp) view = pushed;
        else     view = mq;
        vis = (view.size() > 2) ? 2 : view.size();
        if (preq > vis && !fl) preq = vis;

        rst_n = rn; flush = fl; push_valid = pv; push_pc = ppc;
        push_inst1 = i1; push_inst2 = i2; push_inst2_valid = i2v; pop_count = 2'(preq);

        e.cnt = mq.size();
        e.rdy = rdy;
        e.v1  = (vis >= 1);
        e.v2  = (vis >= 2);
        e.pc1 = e.v1 ? view[0].pc   : 32'h0;
        e.i1  = e.v1 ? view[0].inst : 32'h0;
        e.pc2 = e.v2 ? view[1].pc   : 32'h0;
        e.i2  = e.v2 ? view[1].inst : 32'h0;
        sb.push_back(e);

        if (rn) begin
            if (fl) begin
                mq.delete();
            end else begin
                foreach (pushed[k]) mq.push_back(pushed[k]);
                npop = (preq < vis) ? preq : vis;
                repeat (npop) void'(mq.pop_front());
            end
        end
    endtask

    task automatic idle(input int pop);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, pop);
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] i1, input logic [31:0] i2,
                        input bit i2v, input int pop);
        step(1'b1, 1'b0, 1'b1, pc, i1, i2, i2v, pop);
    endtask

    // Monitor: compares every presented output set against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("count",      32'(count),      32'(e.cnt));
                chk("push_ready", 32'(push_ready), 32'(e.rdy));
                chk("pop_valid1", 32'(pop_valid1), 32'(e.v1));
                chk("pop_valid2", 32'(pop_valid2), 32'(e.v2));
                chk("pop_pc1",    pop_pc1,         e.pc1);
                chk("pop_inst1",  pop_inst1,       e.i1);
                chk("pop_pc2",    pop_pc2,         e.pc2);
                chk("pop_inst2",  pop_inst2,       e.i2);
            end
        end
    end

    initial begin
        logic [31:0] r;
        rst_n = 1'b0; flush = 1'b0; push_valid = 1'b0; push_pc = 32'h0;
        push_inst1 = 32'h0; push_inst2 = 32'h0; push_inst2_valid = 1'b0; pop_count = 2'd0;

        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 0);
        idle(0);

        // First pair, then single pop leaves the second instruction at the head.
        push(32'h1000, 32'h11, 32'h22, 1'b1, 0);
        idle(0);
        idle(1);
        idle(0);
        idle(1);
        idle(0);

        // Fill, blocked push when full, then wrap across slot DEPTH-1 -> 0.
        for (int k = 0; k < 4; k++) push(32'h3000 + 32'(8 * k), 32'hA0 + 32'(k), 32'hB0 + 32'(k), 1'b1, 0);
        push(32'h3900, 32'hEE, 32'hFF, 1'b1, 0);
        idle(2);
        for (int k = 0; k < 3; k++) push(32'h5000 + 32'(8 * k), 32'hC0 + 32'(k), 32'hD0 + 32'(k), 1'b1, 2);
        for (int k = 0; k < 3; k++) idle(2);
        idle(0);

        // Single-instruction push alongside a pop keeps count constant.
        push(32'h1f00, 32'h01, 32'h02, 1'b1, 0);
        push(32'h2000, 32'h03, 32'h0, 1'b0, 0);
        push(32'h2004, 32'h04, 32'h0, 1'b0, 1);
        idle(0);

        // Flush dominates a simultaneous push and pop.
        push(32'h6000, 32'h05, 32'h06, 1'b1, 0);
        step(1'b1, 1'b1, 1'b1, 32'h7000, 32'h07, 32'h08, 1'b1, 2);
        idle(0);

        // Push into an empty queue with a same-cycle pop.
        push(32'h4000, 32'h33, 32'h44, 1'b1, 1);
        idle(0);
        idle(1);
        idle(0);

        for (int n = 0; n < 600; n++) begin
            r = $urandom;
            r[1:0] = 2'b00;
            if (n == 300) begin
                step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 0);
            end else begin
                step(1'b1, ($urandom_range(0, 19) == 0), ($urandom_range(0, 2) != 0), r,
                     $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
            end
        end
        idle(0);

        @(negedge clk);
        #3;
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
